// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display value/controls in, multiplexed anode/cathode drive out
interface seg7_scan_driver_if;
    logic [15:0] DIN;
    logic [3:0]  DP;
    logic        BLANK_LZ;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP_N;
    modport master (output DIN, DP, BLANK_LZ, input AN, SEG, DP_N);
    modport slave  (input DIN, DP, BLANK_LZ, output AN, SEG, DP_N);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit seven-segment scanner with frame-level shadowing
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYC     = 500
) (
    input  logic              CLK,
    input  logic              RST,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP  = CW'(GAP_CYC);

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   sh_val, cur_val;
    logic [3:0]    sh_dp, cur_dp, blank, nib;
    logic          cap, lit;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // The capture edge decodes the value being captured, so a zero-gap slot 0 never shows stale data
    always_comb begin
        cap     = cnt == '0 && dig == 2'd0;
        cur_val = cap ? bus.DIN : sh_val;
        cur_dp  = cap ? bus.DP : sh_dp;
        blank   = {bus.BLANK_LZ && cur_val[15:12] == 4'h0,
                   bus.BLANK_LZ && cur_val[15:8] == 8'h00,
                   bus.BLANK_LZ && cur_val[15:4] == 12'h000,
                   1'b0};
        nib     = cur_val[{dig, 2'b00} +: 4];
        lit     = cnt >= GAP && !blank[dig];
    end

    // Slot counter, digit index and per-frame shadow of the display value
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            dig    <= 2'd0;
            sh_val <= 16'h0000;
            sh_dp  <= 4'h0;
        end else begin
            cnt    <= cnt == LAST ? '0 : cnt + 1'b1;
            dig    <= cnt == LAST ? dig + 2'd1 : dig;
            sh_val <= cur_val;
            sh_dp  <= cur_dp;
        end
    end

    // Registered active-low drive; dark during the gap and for blanked leading zeros
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.AN   <= 4'hF;
            bus.SEG  <= 7'h7F;
            bus.DP_N <= 1'b1;
        end else begin
            bus.AN   <= lit ? ~(4'b0001 << dig) : 4'hF;
            bus.SEG  <= lit ? hex7(nib) : 7'h7F;
            bus.DP_N <= ~(lit & cur_dp[dig]);
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks of the scan driver against an edge-count model
module tb_seg7_scan_driver;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int errors = 0;
    int checks = 0;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.REFRESH_DIV(8), .GAP_CYC(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int          m_n = 0;
    int          m_d, m_ph;
    bit          m_lit;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dpn = 1'b1;

    // Reference: position in the scan is edge count since reset release; frame value taken every 32 edges
    always @(posedge CLK) begin
        if (RST) begin
            m_n = 0; m_val = 16'h0000; m_dp = 4'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
        end else begin
            m_ph = m_n % 8;
            m_d  = (m_n / 8) % 4;
            if (m_n % 32 == 0) begin
                m_val = bus.DIN;
                m_dp  = bus.DP;
            end
            m_lit = m_ph >= 2 && !(bus.BLANK_LZ && m_d > 0 && (m_val >> (4 * m_d)) == 16'h0);
            e_an  = m_lit ? 4'(~(4'b0001 << m_d)) : 4'hF;
            e_seg = m_lit ? hex_tbl[m_val[4*m_d +: 4]] : 7'h7F;
            e_dpn = m_lit ? ~m_dp[m_d] : 1'b1;
            m_n++;
        end
    end

    task automatic release_scan;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] digs [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic [3:0] x_an;
        logic [6:0] x_seg;
        int d;
        bit lit;
        RST = 1'b1; bus.DIN = 16'h1234; bus.DP = 4'h0; bus.BLANK_LZ = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.AN !== 4'hF || bus.SEG !== 7'h7F || bus.DP_N !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: AN=%b SEG=%b DP_N=%b want 1111 1111111 1", bus.AN, bus.SEG, bus.DP_N);
        end
        RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            d = (i / 8) % 4;
            lit = i % 8 >= 2;
            x_an = lit ? 4'(~(4'b0001 << d)) : 4'hF;
            x_seg = lit ? digs[d] : 7'h7F;
            checks++;
            if (bus.AN !== x_an || bus.SEG !== x_seg || bus.DP_N !== 1'b1) begin
                errors++;
                $display("FAIL basic_scan E%0d: AN=%b SEG=%b DP_N=%b want %b %b 1", i, bus.AN, bus.SEG, bus.DP_N, x_an, x_seg);
            end
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL basic_model E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
        end
    endtask

    task automatic test_shadow;
        bus.DIN = 16'h0000; bus.DP = 4'h0; bus.BLANK_LZ = 1'b0;
        release_scan();
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i % 8 >= 2 && (i < 32 || i >= 34)) begin
                checks++;
                if (bus.SEG !== (i < 32 ? 7'b1000000 : 7'b0001110)) begin
                    errors++;
                    $display("FAIL shadow_seg E%0d: SEG=%b want %b", i, bus.SEG, i < 32 ? 7'b1000000 : 7'b0001110);
                end
            end
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL shadow_model E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
            if (i == 4) bus.DIN = 16'hFFFF;
        end
    endtask

    task automatic test_leading_zero;
        int d;
        bus.DIN = 16'h0070; bus.DP = 4'h0; bus.BLANK_LZ = 1'b1;
        release_scan();
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            d = (i / 8) % 4;
            if (i < 32 && d >= 2) begin
                checks++;
                if (bus.AN !== 4'hF || bus.SEG !== 7'h7F || bus.DP_N !== 1'b1) begin
                    errors++;
                    $display("FAIL lz_blank E%0d: AN=%b SEG=%b DP_N=%b want dark", i, bus.AN, bus.SEG, bus.DP_N);
                end
            end
            if (i % 8 >= 2 && (i < 32 ? d < 2 : d == 3)) begin
                checks++;
                if (bus.SEG !== (d == 1 ? 7'b1111000 : 7'b1000000) || bus.AN !== 4'(~(4'b0001 << d))) begin
                    errors++;
                    $display("FAIL lz_digit E%0d: AN=%b SEG=%b for digit %0d", i, bus.AN, bus.SEG, d);
                end
            end
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL lz_model E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
            if (i == 31) bus.BLANK_LZ = 1'b0;
        end
    endtask

    task automatic test_decimal_point;
        bit lit;
        logic x_dpn;
        bus.DIN = 16'h8888; bus.DP = 4'b0100; bus.BLANK_LZ = 1'b0;
        release_scan();
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            lit = i % 8 >= 2;
            x_dpn = !(lit && (i / 8) % 4 == 2);
            checks++;
            if (bus.DP_N !== x_dpn || bus.SEG !== (lit ? 7'b0000000 : 7'h7F)) begin
                errors++;
                $display("FAIL dp E%0d: DP_N=%b SEG=%b want DP_N=%b", i, bus.DP_N, bus.SEG, x_dpn);
            end
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL dp_model E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
        end
    endtask

    task automatic test_mid_reset;
        int d;
        bus.DIN = 16'h5A5A; bus.DP = 4'hF; bus.BLANK_LZ = 1'b0;
        release_scan();
        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL midrst_pre E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.AN !== 4'hF || bus.SEG !== 7'h7F || bus.DP_N !== 1'b1) begin
            errors++;
            $display("FAIL midrst_values: AN=%b SEG=%b DP_N=%b want 1111 1111111 1", bus.AN, bus.SEG, bus.DP_N);
        end
        RST = 1'b0; bus.DIN = 16'hABCD; bus.DP = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            d = i / 8;
            if (i % 8 >= 2) begin
                checks++;
                if (bus.AN !== 4'(~(4'b0001 << d)) || bus.SEG !== (d == 0 ? 7'b0100001 : 7'b1000110)) begin
                    errors++;
                    $display("FAIL midrst_restart E%0d: AN=%b SEG=%b", i, bus.AN, bus.SEG);
                end
            end
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL midrst_model E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
        end
    endtask

    task automatic test_random;
        bus.DIN = 16'($urandom); bus.DP = 4'($urandom); bus.BLANK_LZ = 1'($urandom);
        release_scan();
        for (int i = 0; i < 320; i++) begin
            @(negedge CLK);
            checks++;
            if ($countones(~bus.AN) > 1) begin
                errors++;
                $display("FAIL onehot E%0d: AN=%b", i, bus.AN);
            end
            checks++;
            if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_N !== e_dpn) begin
                errors++;
                $display("FAIL random_model E%0d: got %b %b %b want %b %b %b", i, bus.AN, bus.SEG, bus.DP_N, e_an, e_seg, e_dpn);
            end
            bus.DIN = 16'($urandom);
            bus.DP = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.BLANK_LZ = ~bus.BLANK_LZ;
        end
    endtask

    initial begin
        bus.DIN = 16'h0000; bus.DP = 4'h0; bus.BLANK_LZ = 1'b0;
        @(negedge CLK);
        test_reset();
        test_shadow();
        test_leading_zero();
        test_decimal_point();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It consumes the 16-bit 7-segment register published by the GPIO peripheral and scans it out one hex digit at a time. It sits between GPIO and the FPGA pins, in the same clock domain as the core. The value is captured once per scan frame, so a CPU store mid-frame never shows a torn display.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GAP_CYC, 500: blanking cycles at the start of each slot (anti-ghosting); must satisfy 0 ≤ GAP_CYC < REFRESH_DIV.

Ports (clock and reset first):
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN  in  16  value to display. Nibble k drives digit k; digit 0 is rightmost.
- DP  in  4  decimal-point request per digit, active-high.
- BLANK_LZ  in  1  1 = suppress leading zeros.
- AN  out  4  digit anodes, active-low; AN[k] selects digit k.
- SEG  out  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- DP_N  out  1  decimal-point cathode, active-low.

## Operation
- Internal state:
  - slot counter `cnt`, range 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - digit index `dig`, 2 bits, sequence 0→1→2→3→0.
  - shadow registers `sh_val[15:0]` and `sh_dp[3:0]`.
- Slot sequencing:
  - `cnt` increments every cycle.
  - When `cnt` = REFRESH_DIV-1, `cnt` returns to 0 and `dig` increments, wrapping 3→0.
- Frame capture: on every edge where `cnt`=0 and `dig`=0, load DIN→`sh_val` and DP→`sh_dp`. This includes the first edge after reset. DIN/DP are ignored at all other times.
- Slot phases, decoded from `cnt`:
  - GAP phase (`cnt` < GAP_CYC): AN=1111, SEG=1111111, DP_N=1.
  - ON phase (otherwise): AN = one-hot-low on `dig`; SEG = hex decode of nibble `dig` of `sh_val`; DP_N = ~`sh_dp[dig]`.
- Hex decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (BLANK_LZ=1, evaluated on `sh_val`):
  - Digit k ∈ {3,2,1} is blank when `sh_val[15:4k]` == 0.
  - A blank digit behaves as GAP for its whole slot (AN, SEG, DP_N all off), even if its DP bit is set.
  - Digit 0 is never blanked.
  - BLANK_LZ is sampled live, not shadowed.
- Outputs AN, SEG, DP_N are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values (edge with RST=1): AN=1111, SEG=1111111, DP_N=1, `cnt`=0, `dig`=0, `sh_val`=0, `sh_dp`=0.
- Latency: outputs reflect `cnt`/`dig` from the previous cycle (1-cycle register).
- Per-slot timing: let E0 be the first edge with RST=0. Slot d occupies edges E(d·DIV) .. E(d·DIV+DIV-1).
  - Output after edges E(d·DIV) .. E(d·DIV+GAP_CYC-1): dark.
  - Output after edges E(d·DIV+GAP_CYC) .. E(d·DIV+DIV-1): lit.
  - Result: each digit is lit for DIV-GAP_CYC cycles; one full frame is 4·DIV cycles.
- GAP_CYC=0: no dark interval. The anode switches directly from one digit to the next.
- DIN change mid-frame: the display is unaffected until the next frame-capture edge. A change on exactly the capture edge is captured.
- RST asserted mid-frame: the next edge forces reset values regardless of phase. The scan restarts at digit 0 with a fresh capture on the first edge after RST falls.
- At most one AN bit is low on any cycle.

## Test plan
(Benches use REFRESH_DIV=8, GAP_CYC=2.)
- Reset/basic scan: hold RST=1 for 3 edges → AN=1111, SEG=1111111, DP_N=1. Release with DIN=16'h1234, DP=0, BLANK_LZ=0:
  - After E0–E1: dark.
  - After E2–E7: AN=1110, SEG=0011001 ("4").
  - After E10–E15: AN=1101, SEG=0110000 ("3").
  - Same pattern for "2" and "1". The sequence repeats from E32.
- Shadowing: DIN=16'h0000 at capture. Change DIN to 16'hFFFF at E5 → digits 1..3 show "0" (1000000) for the rest of the frame. From E34 onward, digit 0 shows "F" (0001110).
- Leading zeros: DIN=16'h0070, BLANK_LZ=1 → digits 3 and 2 stay AN=1111 for their whole slots; digit 1 shows "7" (1111000); digit 0 shows "0". Set BLANK_LZ=0 → digit 3 shows "0" (1000000) in its next slot.
- Decimal point: DP=4'b0100, DIN=16'h8888 → DP_N=0 only during digit 2's ON phase. DP_N=1 during all gaps and other digits; SEG=0000000.
- Reset mid-frame: assert RST at E19 (digit 2, ON phase) → outputs at reset values after that edge. On release, the scan restarts at digit 0 with a fresh capture.
- One-hot check: random DIN/DP/BLANK_LZ for 10 frames → AN is never more than one bit low. Every lit digit's SEG matches the decode of the captured nibble.
